// File: rtl/res_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : res_phase_scheduler
// Purpose  : Runs the distance-transform phases in order and arbitrates the
//            shared result-memory port between the active engine and the host.
// Revision : 1.0 - initial release
// ============================================================================
module res_phase_scheduler #(
    parameter int NPH      = 3,
    parameter int AW       = 14,
    parameter int DW       = 8,
    parameter int HOST_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [1:0]        phase,
    output logic [NPH-1:0]    ph_start,
    input  logic [NPH-1:0]    ph_done,
    input  logic [NPH-1:0]    ph_req,
    input  logic [NPH-1:0]    ph_rd,
    input  logic [NPH-1:0]    ph_wr,
    input  logic [NPH*AW-1:0] ph_addr,
    input  logic [NPH*DW-1:0] ph_do,
    output logic [NPH-1:0]    ph_gnt,
    output logic [NPH-1:0]    ph_rvalid,
    input  logic              host_req,
    input  logic              host_wr,
    input  logic [AW-1:0]     host_addr,
    input  logic [DW-1:0]     host_do,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DW-1:0]     rdata,
    output logic              res_rd,
    output logic              res_wr,
    output logic [AW-1:0]     res_addr,
    output logic [DW-1:0]     res_do,
    input  logic [DW-1:0]     res_di
);

    localparam int c_OW      = $clog2(NPH + 1);
    localparam int c_HOST_ID = NPH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_phase, w_phase_nxt;
    logic [NPH-1:0]      r_ph_start, w_ph_start_nxt;
    logic [7:0]          r_hwait;
    logic                r_tag1_vld, r_tag2_vld;
    logic [c_OW-1:0]     r_tag1_own, r_tag2_own;

    logic                w_run, w_act_req, w_force, w_host_win, w_eng_win, w_grant;
    logic                w_op_rd, w_op_wr;
    logic [AW-1:0]       w_op_addr, w_eng_addr;
    logic [DW-1:0]       w_op_do, w_eng_do;
    logic [c_OW-1:0]     w_op_own;

    // Phase sequencing; ph_start is registered so it lands on the first RUN cycle
    always_comb begin
        w_state_nxt    = r_state;
        w_phase_nxt    = r_phase;
        w_ph_start_nxt = '0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt    = S_RUN;
                    w_phase_nxt    = 2'd0;
                    w_ph_start_nxt = NPH'(1);
                end
            end
            S_RUN: begin
                if (ph_done[r_phase]) begin
                    if (r_phase == 2'(NPH - 1)) begin
                        w_state_nxt = S_DONE;
                        w_phase_nxt = 2'd0;
                    end else begin
                        w_phase_nxt    = r_phase + 2'd1;
                        w_ph_start_nxt = NPH'(1) << (r_phase + 2'd1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_phase_nxt = 2'd0;
            end
        endcase
    end

    assign w_run      = (r_state == S_RUN);
    assign w_act_req  = w_run && ph_req[r_phase];
    assign w_force    = host_req && (r_hwait == 8'(HOST_MAX));
    assign w_host_win = host_req && (!w_act_req || w_force);
    assign w_eng_win  = w_act_req && !w_host_win;
    assign w_grant    = w_host_win || w_eng_win;
    assign w_eng_addr = ph_addr[32'(r_phase)*AW +: AW];
    assign w_eng_do   = ph_do[32'(r_phase)*DW +: DW];

    // Write takes precedence when an engine asserts rd and wr together
    always_comb begin
        w_op_rd   = 1'b0;
        w_op_wr   = 1'b0;
        w_op_addr = w_eng_addr;
        w_op_do   = w_eng_do;
        w_op_own  = c_OW'(r_phase);
        if (w_host_win) begin
            w_op_wr   = host_wr;
            w_op_rd   = !host_wr;
            w_op_addr = host_addr;
            w_op_do   = host_do;
            w_op_own  = c_OW'(c_HOST_ID);
        end else if (w_eng_win) begin
            w_op_wr = ph_wr[r_phase];
            w_op_rd = ph_rd[r_phase] && !ph_wr[r_phase];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_phase    <= 2'd0;
            r_ph_start <= '0;
            r_hwait    <= 8'd0;
            res_rd     <= 1'b0;
            res_wr     <= 1'b0;
            res_addr   <= '0;
            res_do     <= '0;
            r_tag1_vld <= 1'b0;
            r_tag1_own <= '0;
            r_tag2_vld <= 1'b0;
            r_tag2_own <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_ph_start <= w_ph_start_nxt;
            r_hwait    <= (host_req && !w_host_win) ? r_hwait + 8'd1 : 8'd0;
            res_rd     <= w_op_rd;
            res_wr     <= w_op_wr;
            if (w_grant) begin
                res_addr <= w_op_addr;
                res_do   <= w_op_do;
            end
            // Owner tag travels alongside the read so a phase change cannot misroute it
            r_tag1_vld <= w_op_rd;
            r_tag1_own <= w_op_own;
            r_tag2_vld <= r_tag1_vld;
            r_tag2_own <= r_tag1_own;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NPH; k++) begin : g_eng
            assign ph_gnt[k]    = w_eng_win && (r_phase == 2'(k)) && !reset;
            assign ph_rvalid[k] = r_tag2_vld && (r_tag2_own == c_OW'(k));
        end
    endgenerate

    assign host_gnt    = w_host_win && !reset;
    assign host_rvalid = r_tag2_vld && (r_tag2_own == c_OW'(c_HOST_ID));
    assign busy        = w_run;
    assign done        = (r_state == S_DONE);
    assign phase       = r_phase;
    assign ph_start    = r_ph_start;
    assign rdata       = res_di;

endmodule
`default_nettype wire

// File: tb/tb_res_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_res_phase_scheduler
// Purpose  : Randomized bench for res_phase_scheduler against a cycle-level
//            behavioural model of sequencing, arbitration and read returns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_res_phase_scheduler;

    localparam int NPH      = 3;
    localparam int AW       = 14;
    localparam int DW       = 8;
    localparam int HOST_MAX = 15;
    localparam int NCYC     = 4000;

    logic              clk = 1'b0;
    logic              reset, start;
    logic              busy, done;
    logic [1:0]        phase;
    logic [NPH-1:0]    ph_start, ph_done, ph_req, ph_rd, ph_wr, ph_gnt, ph_rvalid;
    logic [NPH*AW-1:0] ph_addr;
    logic [NPH*DW-1:0] ph_do;
    logic              host_req, host_wr, host_gnt, host_rvalid;
    logic [AW-1:0]     host_addr, res_addr;
    logic [DW-1:0]     host_do, rdata, res_do, res_di;
    logic              res_rd, res_wr;

    int n_checks = 0;
    int n_errors = 0;

    res_phase_scheduler #(.NPH(NPH), .AW(AW), .DW(DW), .HOST_MAX(HOST_MAX)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .phase(phase), .ph_start(ph_start), .ph_done(ph_done), .ph_req(ph_req),
        .ph_rd(ph_rd), .ph_wr(ph_wr), .ph_addr(ph_addr), .ph_do(ph_do),
        .ph_gnt(ph_gnt), .ph_rvalid(ph_rvalid), .host_req(host_req),
        .host_wr(host_wr), .host_addr(host_addr), .host_do(host_do),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .rdata(rdata),
        .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do),
        .res_di(res_di)
    );

    always #5 clk = ~clk;

    // Result memory seen by the DUT pins
    logic [DW-1:0] pmem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (res_wr) pmem[res_addr] <= res_do;
        if (res_rd) res_di <= pmem[res_addr];
    end

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'(a * 7 + 3);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int            m_mode;          // 0 idle, 1 run, 2 done
    int            m_ph, m_hwait;
    bit            m_first;
    bit            e_rd, e_wr;
    int            e_addr, e_do;
    logic [DW-1:0] wmem [int];
    bit            pend_v;
    int            pend_a, pend_d;
    int            dq_own[$];
    int            dq_dat[$];

    task automatic model_reset();
        m_mode = 0; m_ph = 0; m_hwait = 0; m_first = 0;
        e_rd = 0; e_wr = 0; e_addr = 0; e_do = 0; pend_v = 0;
        dq_own = '{-1, -1};
        dq_dat = '{0, 0};
    endtask

    initial begin
        bit stress;
        for (int i = 0; i < (1 << AW); i++) pmem[i] = init_val(i);
        res_di = '0;
        model_reset();
        stress = 0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            int who, own2, rd_v, addr, dat;
            bit op_rd, op_wr;
            if (cyc % 64 == 0) stress = ($urandom_range(0, 2) == 0);
            reset    = (cyc < 2) || ($urandom_range(0, 299) == 0);
            start    = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < NPH; k++) begin
                ph_done[k] = stress ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 9) == 0);
                ph_req[k]  = stress ? 1'b1 : 1'($urandom_range(0, 1));
                ph_rd[k]   = 1'($urandom_range(0, 1));
                ph_wr[k]   = ($urandom_range(0, 2) == 0);
                ph_addr[k*AW +: AW] = ($urandom_range(0, 9) == 0) ? AW'(129) : AW'($urandom_range(0, 15));
                ph_do[k*DW +: DW]   = DW'($urandom);
            end
            host_req  = stress ? 1'b1 : 1'($urandom_range(0, 1));
            host_wr   = 1'($urandom_range(0, 1));
            host_addr = ($urandom_range(0, 9) == 0) ? AW'(200) : AW'($urandom_range(0, 15));
            host_do   = DW'($urandom);

            @(negedge clk);
            who = -1;
            if (!reset) begin
                if (m_mode == 1 && ph_req[m_ph] && !(host_req && m_hwait == HOST_MAX)) who = m_ph;
                else if (host_req) who = NPH;
            end
            own2 = reset ? -1 : dq_own[1];

            check_eq("busy",     32'(busy),     32'(!reset && m_mode == 1));
            check_eq("done",     32'(done),     32'(!reset && m_mode == 2));
            check_eq("phase",    32'(phase),    reset ? 0 : (m_mode == 1 ? m_ph : 0));
            check_eq("ph_start", 32'(ph_start), (!reset && m_mode == 1 && m_first) ? (1 << m_ph) : 0);
            check_eq("ph_gnt",   32'(ph_gnt),   (who >= 0 && who < NPH) ? (1 << who) : 0);
            check_eq("host_gnt", 32'(host_gnt), 32'(who == NPH));
            check_eq("ph_rvalid",   32'(ph_rvalid),   (own2 >= 0 && own2 < NPH) ? (1 << own2) : 0);
            check_eq("host_rvalid", 32'(host_rvalid), 32'(own2 == NPH));
            check_eq("res_rd",   32'(res_rd),   32'(!reset && e_rd));
            check_eq("res_wr",   32'(res_wr),   32'(!reset && e_wr));
            if (reset) begin
                check_eq("res_addr_rst", 32'(res_addr), 0);
                check_eq("res_do_rst",   32'(res_do),   0);
            end else begin
                if (e_rd || e_wr) check_eq("res_addr", 32'(res_addr), 32'(e_addr));
                if (e_wr)         check_eq("res_do",   32'(res_do),   32'(e_do));
                if (own2 >= 0)    check_eq("rdata",    32'(rdata),    32'(dq_dat[1]));
            end

            if (reset) begin
                model_reset();
            end else begin
                if (pend_v) wmem[pend_a] = DW'(pend_d);
                pend_v = 0;
                op_rd = 0; op_wr = 0; addr = 0; dat = 0;
                if (who == NPH) begin
                    op_wr = host_wr; op_rd = !host_wr;
                    addr = int'(host_addr); dat = int'(host_do);
                end else if (who >= 0) begin
                    op_wr = ph_wr[who]; op_rd = ph_rd[who] && !ph_wr[who];
                    addr = int'(ph_addr[who*AW +: AW]); dat = int'(ph_do[who*DW +: DW]);
                end
                rd_v = wmem.exists(addr) ? int'(wmem[addr]) : int'(init_val(addr));
                if (op_wr) begin pend_v = 1; pend_a = addr; pend_d = dat; end
                dq_own.push_front(op_rd ? who : -1);
                dq_dat.push_front(rd_v);
                void'(dq_own.pop_back());
                void'(dq_dat.pop_back());
                e_rd = op_rd; e_wr = op_wr;
                if (who >= 0) begin e_addr = addr; e_do = dat; end
                m_hwait = (host_req && who != NPH) ? m_hwait + 1 : 0;
                if (m_mode != 1) begin
                    m_first = 0;
                    if (start) begin m_mode = 1; m_ph = 0; m_first = 1; end
                end else begin
                    m_first = 0;
                    if (ph_done[m_ph]) begin
                        if (m_ph == NPH - 1) begin m_mode = 2; m_ph = 0; end
                        else begin m_ph = m_ph + 1; m_first = 1; end
                    end
                end
            end

            @(posedge clk);
            #1;
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
